// File: rtl/axi_id_remap_pkg.sv
// axi_id_remap_pkg: slot record, remapper widths and the matching-slot encoder.
package axi_id_remap_pkg;
    localparam int ID_IN_W = 8;
    localparam int ID_OUT_W = 4;
    localparam int CNT_W = 4;
    localparam int NS = 2 ** ID_OUT_W;
    localparam logic [CNT_W-1:0] CMAX = '1;
    typedef struct packed {
        logic busy;
        logic [ID_IN_W-1:0] id;
        logic [CNT_W-1:0] cnt;
    } slot_t;
    typedef slot_t [NS-1:0] slots_t;
    // returns {hit, index}; at most one busy slot ever holds a given id
    function automatic logic [ID_OUT_W:0] match_enc(slots_t s, logic [ID_IN_W-1:0] id);
        match_enc = '0;
        for (int i = 0; i < NS; i++)
            if (s[i].busy && s[i].id == id) match_enc = {1'b1, ID_OUT_W'(i)};
    endfunction
endpackage

// File: rtl/axi_id_remap_table_if.sv
// axi_id_remap_table_if: allocation, release and status signals of the slot table.
interface axi_id_remap_table_if;
    import axi_id_remap_pkg::*;
    logic alloc_valid;
    logic [ID_IN_W-1:0] alloc_id;
    logic alloc_ready;
    logic [ID_OUT_W-1:0] alloc_slot;
    logic alloc_fire;
    logic rel_valid;
    logic [ID_OUT_W-1:0] rel_slot;
    logic [ID_IN_W-1:0] rel_id;
    logic rel_hit;
    logic empty;
    logic [ID_OUT_W:0] busy_slots;
    modport master(output alloc_valid, alloc_id, alloc_fire, rel_valid, rel_slot,
                   input alloc_ready, alloc_slot, rel_id, rel_hit, empty, busy_slots);
    modport slave(input alloc_valid, alloc_id, alloc_fire, rel_valid, rel_slot,
                  output alloc_ready, alloc_slot, rel_id, rel_hit, empty, busy_slots);
endinterface

// File: rtl/axi_id_remap_ff1.sv
// axi_id_remap_ff1: lowest-index set bit of a free mask, as index plus found flag.
module axi_id_remap_ff1 #(
    parameter int NS = 16,
    localparam int W = $clog2(NS)
) (
    input logic [NS-1:0] free,
    output logic [W-1:0] idx,
    output logic found
);
    logic [NS-1:0] oh;
    assign oh = free & (~free + NS'(1));
    assign found = |free;
    always_comb begin
        idx = '0;
        for (int i = 0; i < NS; i++)
            idx = oh[i] ? idx | W'(i) : idx;
    end
endmodule

// File: rtl/axi_id_remap_table.sv
// axi_id_remap_table: maps upstream IDs onto downstream slots and counts
// outstanding transactions per slot; restores upstream IDs on responses.
module axi_id_remap_table
    import axi_id_remap_pkg::*;
(
    input logic clk,
    input logic rst_n,
    axi_id_remap_table_if.slave bus
);
    slots_t s, s_nxt;
    logic [NS-1:0] free, inc, dec;
    logic [ID_OUT_W-1:0] free_idx, m_idx;
    logic free_found, m_hit;
    logic [ID_OUT_W:0] cnt_busy;

    always_comb
        for (int i = 0; i < NS; i++) free[i] = ~s[i].busy;

    axi_id_remap_ff1 #(.NS(NS)) u_ff1 (.free(free), .idx(free_idx), .found(free_found));

    assign {m_hit, m_idx} = match_enc(s, bus.alloc_id);
    assign bus.alloc_slot = m_hit ? m_idx : free_found ? free_idx : '0;
    assign bus.alloc_ready = m_hit ? s[m_idx].cnt != CMAX : free_found;
    assign bus.rel_id = s[bus.rel_slot].id;
    assign bus.rel_hit = s[bus.rel_slot].busy;

    // alloc and release on one slot cancel; selection always sees pre-edge state
    always_comb begin
        s_nxt = s;
        for (int i = 0; i < NS; i++) begin
            inc[i] = bus.alloc_fire && bus.alloc_slot == ID_OUT_W'(i);
            dec[i] = bus.rel_valid && bus.rel_hit && bus.rel_slot == ID_OUT_W'(i);
            s_nxt[i].cnt = s[i].cnt + CNT_W'(inc[i]) - CNT_W'(dec[i]);
            s_nxt[i].busy = s_nxt[i].cnt != '0;
            s_nxt[i].id = inc[i] && !s[i].busy ? bus.alloc_id : s[i].id;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) s <= '0;
        else s <= s_nxt;

    always_comb begin
        cnt_busy = '0;
        for (int i = 0; i < NS; i++) cnt_busy = cnt_busy + (ID_OUT_W + 1)'(s[i].busy);
    end
    assign bus.busy_slots = cnt_busy;
    assign bus.empty = cnt_busy == '0;
endmodule

// File: tb/tb_axi_id_remap_table.sv
// tb_axi_id_remap_table: directed vectors; expectations queued by stimulus,
// compared by a negedge monitor for the cycle they were issued in.
module tb_axi_id_remap_table;
    localparam int RDY = 0, SLOT = 1, RID = 2, HIT = 3, EMPTY = 4, BUSY = 5;
    typedef struct {
        string name;
        int sig;
        int v;
        int cyc;
    } exp_t;
    exp_t q[$];
    logic clk = 0, rst_n = 0;
    int cyc = 0, n_run = 0, n_fail = 0;

    axi_id_remap_table_if bus();
    axi_id_remap_table dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic int actual(int sig);
        case (sig)
            RDY: return int'(bus.alloc_ready);
            SLOT: return int'(bus.alloc_slot);
            RID: return int'(bus.rel_id);
            HIT: return int'(bus.rel_hit);
            EMPTY: return int'(bus.empty);
            default: return int'(bus.busy_slots);
        endcase
    endfunction

    always @(negedge clk)
        for (int k = q.size() - 1; k >= 0; k--)
            if (q[k].cyc == cyc) begin
                n_run++;
                if (actual(q[k].sig) != q[k].v) begin
                    n_fail++;
                    $display("FAIL %s: got %0h expected %0h (cycle %0d)", q[k].name,
                             actual(q[k].sig), q[k].v, cyc);
                end
                q.delete(k);
            end

    task automatic ex(input string n, input int sig, input int v);
        q.push_back('{n, sig, v, cyc});
    endtask

    task automatic drive(input logic av, input logic [7:0] id, input logic fire,
                         input logic rv, input logic [3:0] rs);
        bus.alloc_valid = av;
        bus.alloc_id = id;
        bus.alloc_fire = fire;
        bus.rel_valid = rv;
        bus.rel_slot = rs;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 0, 0, 0, 0);
        repeat (3) tick;
        rst_n = 1;
        drive(1, 8'h55, 0, 0, 0);
        ex("rst_empty", EMPTY, 1); ex("rst_busy", BUSY, 0);
        ex("rst_rdy", RDY, 1); ex("rst_slot", SLOT, 0); ex("rst_hit", HIT, 0);
        tick;
        // single alloc/release of 0x3C
        drive(1, 8'h3C, 1, 0, 0);
        ex("t1_slot", SLOT, 0); ex("t1_rdy", RDY, 1); ex("t1_empty_pre", EMPTY, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        ex("t1_busy", BUSY, 1); ex("t1_nempty", EMPTY, 0); ex("t1_hit", HIT, 1);
        tick;
        drive(0, 0, 0, 1, 0);
        ex("t1_rel_id", RID, 'h3C); ex("t1_rel_hit", HIT, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        ex("t1_empty_post", EMPTY, 1); ex("t1_hit_post", HIT, 0);
        tick;
        // fill all 16 slots with distinct ids
        for (int i = 0; i < 16; i++) begin
            drive(1, 8'(i), 1, 0, 0);
            ex($sformatf("t2_slot%0d", i), SLOT, i); ex($sformatf("t2_rdy%0d", i), RDY, 1);
            tick;
        end
        drive(1, 8'h10, 0, 0, 0);
        ex("t2_full_rdy", RDY, 0); ex("t2_full_slot", SLOT, 0); ex("t2_full_busy", BUSY, 16);
        tick;
        drive(0, 0, 0, 1, 5);
        ex("t2_rel5_id", RID, 5); ex("t2_rel5_hit", HIT, 1);
        tick;
        drive(1, 8'h10, 1, 0, 0);
        ex("t2_reuse_slot", SLOT, 5); ex("t2_reuse_rdy", RDY, 1); ex("t2_busy15", BUSY, 15);
        tick;
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 1, 4'(i));
            ex($sformatf("t2_drain_id%0d", i), RID, i == 5 ? 'h10 : i);
            tick;
        end
        drive(0, 0, 0, 0, 0);
        ex("t2_empty", EMPTY, 1);
        tick;
        // same id saturates one slot's counter
        for (int i = 0; i < 15; i++) begin
            drive(1, 8'hA1, 1, 0, 0);
            ex($sformatf("t3_slot%0d", i), SLOT, 0); ex($sformatf("t3_rdy%0d", i), RDY, 1);
            tick;
        end
        drive(1, 8'hA1, 0, 0, 0);
        ex("t3_sat_rdy", RDY, 0); ex("t3_sat_slot", SLOT, 0); ex("t3_busy1", BUSY, 1);
        tick;
        drive(1, 8'hA1, 0, 1, 0);
        ex("t3_rel_hit", HIT, 1); ex("t3_rdy_pre", RDY, 0);
        tick;
        drive(1, 8'hA1, 0, 0, 0);
        ex("t3_rdy_post", RDY, 1);
        tick;
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, 0, 1, 0);
            tick;
        end
        drive(0, 0, 0, 0, 0);
        ex("t3_empty", EMPTY, 1);
        tick;
        // concurrent alloc/release
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h20 + 8'(i), 1, 0, 0);
            ex($sformatf("t4_slot%0d", i), SLOT, i);
            tick;
        end
        drive(1, 8'h22, 1, 1, 2);
        ex("t4_same_slot", SLOT, 2); ex("t4_same_rdy", RDY, 1);
        ex("t4_same_hit", HIT, 1); ex("t4_same_rid", RID, 'h22);
        tick;
        drive(1, 8'h77, 1, 1, 2);
        ex("t4_new_slot", SLOT, 3); ex("t4_new_hit", HIT, 1); ex("t4_busy3", BUSY, 3);
        tick;
        drive(1, 8'h78, 0, 0, 2);
        ex("t4_freed_hit", HIT, 0); ex("t4_freed_slot", SLOT, 2); ex("t4_busy3b", BUSY, 3);
        tick;
        drive(0, 0, 0, 1, 9);
        ex("t5_free9_hit", HIT, 0);
        tick;
        drive(1, 8'h80, 1, 0, 0);
        ex("t5_busy_unch", BUSY, 3); ex("t5_slot2", SLOT, 2);
        tick;
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'h81 + 8'(i), 1, 0, 0);
            ex($sformatf("t5_slot%0d", i + 4), SLOT, i + 4);
            tick;
        end
        drive(1, 8'h81, 0, 0, 4);
        ex("t5_busy8", BUSY, 8); ex("t5_hit4", HIT, 1);
        tick;
        // asynchronous reset mid-operation
        drive(1, 8'h81, 0, 0, 4);
        #1 rst_n = 0;
        #1;
        ex("t5_arst_empty", EMPTY, 1); ex("t5_arst_busy", BUSY, 0);
        ex("t5_arst_hit", HIT, 0); ex("t5_arst_slot", SLOT, 0); ex("t5_arst_rdy", RDY, 1);
        tick;
        rst_n = 1;
        drive(0, 0, 0, 1, 4);
        ex("t5_post_hit", HIT, 0);
        tick;
        drive(0, 0, 0, 0, 0);
        ex("t5_post_empty", EMPTY, 1);
        tick;
        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
